// File: rtl/bram_8192x2_arbiter_if.sv
// Request/response and BRAM-port bundle for bram_8192x2_arbiter.
// The arbiter uses the slave modport; the requester/BRAM side uses master.
interface bram_8192x2_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [25:0] req_addr;
    logic [3:0]  req_wdata;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_rdata;
    logic        mem_ce;
    logic        mem_we;
    logic [12:0] mem_a;
    logic [1:0]  mem_d;
    logic [1:0]  mem_wem;
    logic [1:0]  mem_q;
    logic        init_done;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_ce, mem_we, mem_a, mem_d, mem_wem, init_done
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_ce, mem_we, mem_a, mem_d, mem_wem, init_done
    );
endinterface

// File: rtl/bram_8192x2_arbiter.sv
// Two-requester round-robin arbiter in front of one port of an 8192x2 BRAM.
// Define BRAM_ARB_INIT_EN to compile in the post-reset clear sweep (INIT state).
module bram_8192x2_arbiter #(
    parameter logic [1:0] INIT_VAL = 2'b00
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_8192x2_arbiter_if.slave  bus
);

    logic [12:0] addr_arr  [2];
    logic [1:0]  wdata_arr [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[13*gi +: 13];
            assign wdata_arr[gi] = bus.req_wdata[2*gi +: 2];
        end
    endgenerate

    logic       last_grant_reg;
    logic       rd_pend_reg;
    logic       rd_who_reg;
    logic [1:0] rdata_hold_reg;

    logic       serving;
    logic       accept;
    logic       gnt_idx;
    logic [1:0] ready_next;

`ifdef BRAM_ARB_INIT_EN
    typedef enum logic {ST_INIT, ST_SERVE} state_t;
    state_t      state_reg;
    logic [12:0] init_cnt_reg;
    logic        init_done_reg;

    assign serving       = (state_reg == ST_SERVE);
    assign bus.init_done = init_done_reg & ~rst;
`else
    assign serving       = 1'b1;
    assign bus.init_done = ~rst;
`endif

    // Ready is combinational so a lone requester is granted with no bubble.
    always_comb begin
        ready_next = 2'b00;
        gnt_idx    = 1'b0;
        if (!rst && serving) begin
            if (bus.req_valid == 2'b01) begin
                gnt_idx = 1'b0;
            end else if (bus.req_valid == 2'b10) begin
                gnt_idx = 1'b1;
            end else if (bus.req_valid == 2'b11) begin
                gnt_idx = ~last_grant_reg;
            end
            if (bus.req_valid != 2'b00) begin
                ready_next = gnt_idx ? 2'b10 : 2'b01;
            end
        end
    end

    assign accept        = |ready_next;
    assign bus.req_ready = ready_next;

    // The idle data bus parks at INIT_VAL; it is qualified by mem_ce anyway.
    always_comb begin
        bus.mem_ce  = 1'b0;
        bus.mem_we  = 1'b0;
        bus.mem_a   = 13'd0;
        bus.mem_d   = INIT_VAL;
        bus.mem_wem = 2'b00;
        if (accept) begin
            bus.mem_ce  = 1'b1;
            bus.mem_we  = bus.req_we[gnt_idx];
            bus.mem_a   = addr_arr[gnt_idx];
            bus.mem_d   = wdata_arr[gnt_idx];
            bus.mem_wem = 2'b11;
        end
`ifdef BRAM_ARB_INIT_EN
        else if (!rst && state_reg == ST_INIT) begin
            bus.mem_ce  = 1'b1;
            bus.mem_we  = 1'b1;
            bus.mem_a   = init_cnt_reg;
            bus.mem_d   = INIT_VAL;
            bus.mem_wem = 2'b11;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            rd_pend_reg    <= 1'b0;
            rd_who_reg     <= 1'b0;
            rdata_hold_reg <= 2'b00;
`ifdef BRAM_ARB_INIT_EN
            state_reg      <= ST_INIT;
            init_cnt_reg   <= 13'd0;
            init_done_reg  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                last_grant_reg <= gnt_idx;
                rd_who_reg     <= gnt_idx;
            end
            rd_pend_reg <= accept & ~bus.req_we[gnt_idx];
            if (rd_pend_reg) begin
                rdata_hold_reg <= bus.mem_q;
            end
`ifdef BRAM_ARB_INIT_EN
            if (state_reg == ST_INIT) begin
                init_cnt_reg <= init_cnt_reg + 13'd1;
                if (init_cnt_reg == 13'h1FFF) begin
                    state_reg     <= ST_SERVE;
                    init_done_reg <= 1'b1;
                end
            end
`endif
        end
    end

    // BRAM data arrives the cycle after the read enable, so it is forwarded live.
    assign bus.rsp_valid = (rd_pend_reg && !rst) ? (rd_who_reg ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_rdata = rst ? 2'b00 : (rd_pend_reg ? bus.mem_q : rdata_hold_reg);

endmodule

// File: tb/tb_bram_8192x2_arbiter.sv
// Directed bench for bram_8192x2_arbiter with a write-first BRAM model
// and a queue of expected per-cycle responses.
module tb_bram_8192x2_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    bram_8192x2_arbiter_if bus ();

    bram_8192x2_arbiter #(.INIT_VAL(2'b00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Write-first BRAM model with a one-cycle registered read.
    logic [1:0] bram [8192];
    logic [1:0] q_reg = 2'b00;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8192; i++) bram[i] <= 2'(i) ^ 2'b01;
        end else if (bus.mem_ce) begin
            if (bus.mem_we) begin
                bram[bus.mem_a] <= (bus.mem_d & bus.mem_wem) | (bram[bus.mem_a] & ~bus.mem_wem);
                q_reg           <= (bus.mem_d & bus.mem_wem) | (bram[bus.mem_a] & ~bus.mem_wem);
            end else begin
                q_reg <= bram[bus.mem_a];
            end
        end
    end
    assign bus.mem_q = q_reg;

    typedef struct packed {
        logic [1:0] v;
        logic [1:0] d;
    } rsp_t;

    rsp_t       exp_q [$];
    logic [1:0] ref_mem [8192];
    logic       last_m;
    logic [1:0] hold_m;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, check grant/BRAM port, then
    // check the response one clock later.
    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [12:0] a0, input logic [12:0] a1,
                        input logic [1:0] d0, input logic [1:0] d1);
        int         g;
        logic [1:0] exp_rdy;
        logic [12:0] ga;
        logic [1:0] gd;
        rsp_t       e;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
        #1;
        g = 0;
        exp_rdy = 2'b00;
        if (v == 2'b10) g = 1;
        else if (v == 2'b11) g = last_m ? 0 : 1;
        if (v != 2'b00) exp_rdy = 2'b01 << g;
        chk("req_ready", 16'(bus.req_ready), 16'(exp_rdy));
        chk("mem_ce", 16'(bus.mem_ce), 16'(v != 2'b00));
        e.v = 2'b00;
        e.d = hold_m;
        if (v != 2'b00) begin
            ga = (g == 1) ? a1 : a0;
            gd = (g == 1) ? d1 : d0;
            chk("mem_we", 16'(bus.mem_we), 16'(we[g]));
            chk("mem_a", 16'(bus.mem_a), 16'(ga));
            if (we[g]) begin
                chk("mem_d", 16'(bus.mem_d), 16'(gd));
                ref_mem[ga] = gd;
            end else begin
                e.v = exp_rdy;
                e.d = ref_mem[ga];
            end
            last_m = g[0];
        end else begin
            chk("mem_we_idle", 16'(bus.mem_we), 16'd0);
        end
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("rsp_valid", 16'(bus.rsp_valid), 16'(e.v));
        chk("rsp_rdata", 16'(bus.rsp_rdata), 16'(e.d));
        if (e.v != 2'b00) hold_m = e.d;
        $display("step valid=%b we=%b ready=%b rsp_valid=%b rsp_rdata=%b",
                 v, we, exp_rdy, bus.rsp_valid, bus.rsp_rdata);
    endtask

`ifdef BRAM_ARB_INIT_EN
    task automatic sweep(input int n, output int bad);
        bad = 0;
        for (int k = 0; k < n; k++) begin
            #1;
            if (!(bus.mem_ce === 1'b1 && bus.mem_we === 1'b1 && bus.mem_wem === 2'b11 &&
                  bus.mem_d === 2'b00 && bus.mem_a === k[12:0] &&
                  bus.req_ready === 2'b00 && bus.init_done === 1'b0)) bad++;
            @(negedge clk);
        end
        $display("sweep cycles=%0d bad=%0d", n, bad);
    endtask
`endif

    initial begin
        int bad;
        for (int i = 0; i < 8192; i++) ref_mem[i] = 2'(i) ^ 2'b01;
        last_m = 1'b1;
        hold_m = 2'b00;
        bad = 0;
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) @(negedge clk);
        preload = 1'b0;
        #1;
        chk("rst_req_ready", 16'(bus.req_ready), 16'd0);
        chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("rst_rsp_rdata", 16'(bus.rsp_rdata), 16'd0);
        chk("rst_mem_ce", 16'(bus.mem_ce), 16'd0);
        chk("rst_mem_we", 16'(bus.mem_we), 16'd0);
        chk("rst_init_done", 16'(bus.init_done), 16'd0);
        @(negedge clk);

`ifdef BRAM_ARB_INIT_EN
        // Interrupted sweep, then a complete one.
        rst = 1'b0;
        sweep(100, bad);
        chk("sweep_prefix", 16'(bad), 16'd0);
        #1;
        chk("sweep_at_100", 16'(bus.mem_a), 16'd100);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("sweep_rst_ce", 16'(bus.mem_ce), 16'd0);
        rst = 1'b0;
        sweep(8192, bad);
        chk("sweep_full", 16'(bad), 16'd0);
        #1;
        chk("init_done_8192", 16'(bus.init_done), 16'd1);
        for (int i = 0; i < 8192; i++) ref_mem[i] = 2'b00;
`else
        rst = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        chk("init_done_no_sweep", 16'(bus.init_done), 16'd1);
`endif

        // Both requesters valid: 0,1,0,1; first read of address 0 right after reset.
        step(2'b11, 2'b00, 13'h0000, 13'h0011, 2'b00, 2'b00);
        step(2'b11, 2'b00, 13'h0002, 13'h0013, 2'b00, 2'b00);
        step(2'b11, 2'b00, 13'h0004, 13'h0015, 2'b00, 2'b00);
        step(2'b11, 2'b00, 13'h0006, 13'h0017, 2'b00, 2'b00);

        // Requester 1 writes, requester 0 reads back on the next cycle.
        step(2'b10, 2'b10, 13'h0000, 13'h1ABC, 2'b00, 2'b10);
        step(2'b01, 2'b00, 13'h1ABC, 13'h0000, 2'b00, 2'b00);
        step(2'b00, 2'b00, 13'h0000, 13'h0000, 2'b00, 2'b00);

        step(2'b10, 2'b10, 13'h0000, 13'h0005, 2'b00, 2'b11);
        step(2'b10, 2'b00, 13'h0000, 13'h0005, 2'b00, 2'b00);

        // Back-to-back single-requester reads.
        for (int i = 0; i < 5; i++)
            step(2'b01, 2'b00, 13'(13'h0200 + i), 13'h0000, 2'b00, 2'b00);

        step(2'b11, 2'b01, 13'h0030, 13'h0031, 2'b10, 2'b01);
        step(2'b11, 2'b10, 13'h0032, 13'h0030, 2'b11, 2'b01);
        step(2'b11, 2'b00, 13'h0030, 13'h0032, 2'b00, 2'b00);
        step(2'b11, 2'b00, 13'h0032, 13'h0030, 2'b00, 2'b00);
        step(2'b00, 2'b00, 13'h0000, 13'h0000, 2'b00, 2'b00);

        // Reset while a read is in flight drops its response.
        bus.req_valid = 2'b01;
        bus.req_we    = 2'b00;
        bus.req_addr  = {13'h0000, 13'h0007};
        #1;
        chk("midrd_ready", 16'(bus.req_ready), 16'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("midrd_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("midrd_rsp_rdata", 16'(bus.rsp_rdata), 16'd0);
        @(negedge clk);
        chk("midrd_rsp_valid_2", 16'(bus.rsp_valid), 16'd0);
        chk("midrd_ready_rst", 16'(bus.req_ready), 16'd0);
        $display("mid-read reset rsp_valid=%b", bus.rsp_valid);
        @(negedge clk);
        last_m = 1'b1;
        hold_m = 2'b00;
        exp_q.delete();
`ifdef BRAM_ARB_INIT_EN
        rst = 1'b0;
        sweep(8192, bad);
        chk("sweep_after_rd_rst", 16'(bad), 16'd0);
        for (int i = 0; i < 8192; i++) ref_mem[i] = 2'b00;
`else
        rst = 1'b0;
`endif
        // Pointer is back to favouring requester 0.
        step(2'b11, 2'b00, 13'h0008, 13'h0009, 2'b00, 2'b00);
        step(2'b11, 2'b00, 13'h1ABC, 13'h0005, 2'b00, 2'b00);
        step(2'b00, 2'b00, 13'h0000, 13'h0000, 2'b00, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
